ultrasonic_scan_scheduler: RTL

- Sequences N HC-SR04-style ultrasonic sensors through one shared echo-timing datapath in round-robin order.
- Per ping: issues the trigger pulse, times the echo, and publishes a tagged measurement with a per-sensor "near" presence flag.
- Sits between the sensor pins and the game/pet logic. Replaces free-running per-sensor counters with one scheduled, timeout-protected measurement engine.

---
 rtl/ultrasonic_pkg.sv | 25 ++
 rtl/echo_sync_edge.sv | 28 ++
 rtl/ultrasonic_scan_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared types and 50 MHz defaults for the ultrasonic scan scheduler.
// Consumers convert meas_cycles to distance with CYCLES_PER_CM.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_e;

  localparam int CLK_HZ             = 50_000_000;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
  localparam int DEF_GAP_CYCLES     = 3_000_000;
  localparam int DEF_CNT_W          = 22;
  // Round-trip echo time per centimetre at 50 MHz.
  localparam int CYCLES_PER_CM      = 2900;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchronizer for one echo pin, with a history flop
// that turns the synchronized level into rise/fall pulses.
module echo_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, h_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      h_q  <= 1'b0;
    end else begin
      s1_q <= echo_i;
      s2_q <= s1_q;
      h_q  <= s2_q;
    end
  end

  assign rise_o = s2_q & ~h_q;
  assign fall_o = ~s2_q & h_q;

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin trigger/echo timing engine shared by N ultrasonic
// sensors; publishes one tagged measurement per ping.
module ultrasonic_scan_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int N_SENSORS      = 2,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  localparam int IDX_W         = idx_width(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     near_thresh,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  output logic                 busy,
  output logic                 meas_valid,
  output logic [IDX_W-1:0]     meas_id,
  output logic [CNT_W-1:0]     meas_cycles,
  output logic                 meas_timeout,
  output logic [N_SENSORS-1:0] near
);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SENSORS - 1);

  logic [N_SENSORS-1:0] rise, fall;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_sync
    echo_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .echo_i (echo[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pub;
  logic [CNT_W-1:0] pub_cycles;
  logic             pub_to;

  logic                 valid_q;
  logic [IDX_W-1:0]     id_q;
  logic [CNT_W-1:0]     cycles_q;
  logic                 to_q;
  logic [N_SENSORS-1:0] near_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pub        = 1'b0;
    pub_cycles = '0;
    pub_to     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (rise[idx_q]) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == TMO) begin
          pub     = 1'b1;
          pub_to  = 1'b1;
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        if (fall[idx_q]) begin
          pub        = 1'b1;
          pub_cycles = cnt_q;
          state_d    = GAP;
          cnt_d      = '0;
        end else if (cnt_q == TMO) begin
          pub        = 1'b1;
          pub_cycles = TMO;
          pub_to     = 1'b1;
          state_d    = GAP;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d = enable ? TRIG : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      cycles_q <= '0;
      to_q     <= 1'b0;
      near_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= pub;
      if (pub) begin
        id_q          <= idx_q;
        cycles_q      <= pub_cycles;
        to_q          <= pub_to;
        near_q[idx_q] <= !pub_to && (pub_cycles < near_thresh);
      end
    end
  end

  always_comb begin
    trigger = '0;
    if (state_q == TRIG) trigger[idx_q] = 1'b1;
  end

  assign busy         = (state_q != IDLE);
  assign meas_valid   = valid_q;
  assign meas_id      = id_q;
  assign meas_cycles  = cycles_q;
  assign meas_timeout = to_q;
  assign near         = near_q;

endmodule
